// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: in-flight writer scoreboard producing per-operand forward selects, stall and a stall counter
//   clk, rst_n           : clock, asynchronous active-low reset
//   issue_valid/wen/rd/lat : instruction presented at issue (lat = cycles until forwardable)
//   src_valid, src_addr  : per-operand read enables and addresses (operand s at [s*ADDR_W +: ADDR_W])
//   flush                : kill the youngest FLUSH_STAGES in-flight entries
//   stall                : hold issue (combinational from entries and src_*)
//   fwd_sel              : per operand 0 = register file, k = entry k-1
//   stall_cnt            : saturating count of stalled cycles
module fwd_hazard_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int NSRC         = 2,
    parameter int STAGES       = 3,
    parameter int FLUSH_STAGES = 1,
    parameter int CNT_W        = 16,
    localparam int SW          = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic [SW-1:0]          issue_lat,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*ADDR_W-1:0] src_addr,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*SW-1:0]     fwd_sel,
    output logic [CNT_W-1:0]       stall_cnt
);
    logic [STAGES-1:0] valid_q, valid_d, wen_q, wen_d;
    logic [ADDR_W-1:0] rd_q [STAGES];
    logic [ADDR_W-1:0] rd_d [STAGES];
    logic [SW-1:0]     rem_q [STAGES];
    logic [SW-1:0]     rem_d [STAGES];
    logic [SW-1:0]     lat_c;
    logic [CNT_W-1:0]  cnt_d;
    assign lat_c = (issue_lat == '0) ? SW'(1) : (issue_lat > SW'(STAGES)) ? SW'(STAGES) : issue_lat;
    always_comb begin
        valid_d = '0;
        wen_d   = '0;
        for (int i = 0; i < STAGES; i++) begin
            rd_d[i]  = '0;
            rem_d[i] = '0;
        end
        valid_d[0] = issue_valid & ~stall;
        wen_d[0]   = issue_wen;
        rd_d[0]    = issue_rd;
        rem_d[0]   = lat_c - SW'(1);
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            wen_d[i]   = wen_q[i-1];
            rd_d[i]    = rd_q[i-1];
            rem_d[i]   = (rem_q[i-1] == '0) ? '0 : rem_q[i-1] - SW'(1);
        end
        for (int i = 0; i < STAGES; i++)
            if (flush && i < FLUSH_STAGES) valid_d[i] = 1'b0;
    end
    // Scan oldest to youngest so the youngest match overwrites and wins.
    always_comb begin
        logic          found;
        logic          rdy;
        logic [SW-1:0] idx;
        stall   = 1'b0;
        fwd_sel = '0;
        for (int s = 0; s < NSRC; s++) begin
            found = 1'b0;
            rdy   = 1'b0;
            idx   = '0;
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (src_valid[s] && valid_q[k] && wen_q[k] && rd_q[k] != '0 &&
                    rd_q[k] == src_addr[s*ADDR_W +: ADDR_W]) begin
                    found = 1'b1;
                    rdy   = (rem_q[k] == '0);
                    idx   = SW'(k + 1);
                end
            end
            fwd_sel[s*SW +: SW] = (found && rdy) ? idx : '0;
            stall = stall | (found & ~rdy);
        end
    end
    assign cnt_d = (stall && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            wen_q     <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                rd_q[i]  <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            wen_q     <= wen_d;
            stall_cnt <= cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                rd_q[i]  <= rd_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end
endmodule
